down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
Programmable down-counting timer with a terminal-count pulse. It is the complement of the free-running up counter: software or an FSM loads a value and the block counts down to zero, optionally through a clock prescaler. It either stops (one-shot) or reloads (periodic). It sits beside the up counter in the timing subsystem and supplies timeouts, periodic ticks and delay generation.

Parameters:
WIDTH, 32, width of the count and load value
PRESCALE_W, 8, width of the prescaler divide field

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
load_val  in  WIDTH  start/reload value, sampled only when start is accepted
prescale  in  PRESCALE_W  divide ratio; count steps once every prescale+1 enabled cycles
auto_reload  in  1  1 = periodic, 0 = one-shot; sampled when start is accepted
start  in  1  single-cycle request: load and run
stop  in  1  single-cycle abort: return to IDLE
en  in  1  count enable; low freezes the timer in HOLD
count  out  WIDTH  current count value
busy  out  1  high in RUN or HOLD
tc  out  1  terminal-count pulse, one cycle per expiry
expired  out  1  level, high in DONE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; count=0, tc=0, busy=0, expired=0.
  - Prescaler counter, reload register and mode register are all cleared.
- State encodings live in the package. States: IDLE, RUN, HOLD, DONE.
- Priority per cycle: stop > start > en/tick.
- stop, any state:
  - next state IDLE; count=0; prescaler cleared; tc=0.
  - A simultaneous terminal tick is discarded, so no tc pulse is produced.
- start, any state (including RUN, i.e. restart):
  - count<=load_val; reload_reg<=load_val; mode<=auto_reload; prescaler<=0.
  - Next state is RUN if en=1, else HOLD.
- RUN with en=0 -> HOLD. Count and prescaler are frozen.
- HOLD with en=1 -> RUN. Counting resumes where it stopped.
- Prescaler in RUN:
  - pcnt increments each cycle.
  - When pcnt==prescale, a tick occurs and pcnt<=0.
  - prescale=0 gives a tick every RUN cycle.
  - prescale is read live; a change mid-run takes effect at the next comparison.
- Tick in RUN with count!=0: count<=count-1.
- Tick in RUN with count==0:
  - tc<=1 for exactly one cycle.
  - Periodic mode: count<=reload_reg, stay in RUN.
  - One-shot mode: count stays 0, state DONE.
- Period is (load_val+1)*(prescale+1) enabled cycles. load_val=0 is legal and gives a period of prescale+1.
- DONE:
  - expired=1, busy=0, count holds 0.
  - Exits only on start or stop.
- Arithmetic:
  - Decrement never occurs at count==0, so no underflow wrap.
  - load_val=2^WIDTH-1 is legal.
- All outputs are registered. tc is high on the cycle after the terminal tick edge.
- en is ignored in IDLE and DONE.
- Reset asserted mid-run clears immediately, with no tc.

Decomposition:
- Package timer_pkg holds:
  - the state enum (IDLE, RUN, HOLD, DONE) as a 2-bit typedef;
  - default WIDTH and PRESCALE_W constants.
- One sub-module: timer_prescaler. Ports: clk, rst, clr, run, prescale; output tick. It holds the pcnt register and the compare logic.
- The top level contains the FSM, count register, reload/mode registers and output registers.

Test Plan:
- One-shot:
  - Stimulus: load_val=3, prescale=0, auto_reload=0, en=1; start pulse.
  - Required: count 3,2,1,0 on successive edges; tc=1 for one cycle on the 4th edge after start is sampled; then expired=1, busy=0, count=0 stable.
- Periodic with prescale:
  - Stimulus: load_val=2, prescale=1, auto_reload=1.
  - Required: tc pulses every 6 cycles for 5 periods; count sequence 2,2,1,1,0,0,2...; busy stays 1.
- Hold:
  - Stimulus: load_val=5, prescale=0; drop en for 3 cycles when count=3.
  - Required: state HOLD, count frozen at 3; resumes 2,1,0; total cycles to tc = 6+3.
- Stop/start collisions:
  - Stimulus: stop on the same cycle as the terminal tick.
  - Required: no tc, state IDLE, count=0.
  - Stimulus: start and stop together.
  - Required: IDLE.
  - Stimulus: start during RUN with load_val=7.
  - Required: count=7 next cycle, prescaler reset.
- Boundaries:
  - Stimulus: load_val=0, prescale=0, periodic.
  - Required: tc high every cycle after the first RUN cycle.
  - Stimulus: load_val=32'hFFFFFFFF.
  - Required: count steps to FFFFFFFE with no wrap glitch.
- Async reset:
  - Stimulus: rst low mid-RUN, released between edges.
  - Required: all outputs 0 immediately; IDLE; no tc after release until a new start.

Source files
------------

// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and default sizes for the down_timer block.
//   timer_state_e     : FSM state encoding (IDLE, RUN, HOLD, DONE)
//   DEFAULT_WIDTH     : default width of the count / load value
//   DEFAULT_PRESCALE_W: default width of the prescaler divide field
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_PRESCALE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // not loaded, count held at zero
        RUN  = 2'd1,  // loaded and counting (en was high)
        HOLD = 2'd2,  // loaded but frozen (en was low)
        DONE = 2'd3   // one-shot expiry reached, waits for start/stop
    } timer_state_e;

endpackage : timer_pkg

// File: rtl/down_timer_if.sv
// -----------------------------------------------------------------------------
// down_timer_if
// Control/status bundle between a timer client and the down_timer block.
//   master modport (client) drives : load_val, prescale, auto_reload,
//                                    start, stop, en
//   master modport (client) reads  : count, busy, tc, expired
//   slave modport (timer) is the mirror image.
// -----------------------------------------------------------------------------
interface down_timer_if
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
);

    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  auto_reload;
    logic                  start;
    logic                  stop;
    logic                  en;

    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc;
    logic                  expired;

    modport master (
        output load_val, prescale, auto_reload, start, stop, en,
        input  count, busy, tc, expired
    );

    modport slave (
        input  load_val, prescale, auto_reload, start, stop, en,
        output count, busy, tc, expired
    );

endinterface : down_timer_if

// File: rtl/down_timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Clock-enable divider for the down timer. While run is high the internal
// counter advances once per cycle; when it equals prescale a one-cycle tick
// is produced and the counter restarts from zero. prescale is compared live,
// so a new ratio applies from the next comparison.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   clr      : synchronous clear of the divider (start/stop), dominates run
//   run      : advance the divider this cycle
//   prescale : divide ratio minus one (0 = tick every run cycle)
//   tick     : combinational tick, valid in the cycle it is consumed
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;
    logic                  at_limit;

    assign at_limit = (pcnt_q == prescale);

    // A clear on the same cycle discards any pending tick.
    assign tick = run && !clr && at_limit;

    always_comb begin
        // NOTE: assign every always_comb output a default first so that no
        // path leaves it unassigned, which would infer a latch.
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (run) begin
            pcnt_d = at_limit ? '0 : pcnt_q + PRESCALE_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule : timer_prescaler

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Programmable down-counting timer with terminal-count pulse. A start loads
// load_val and counts down to zero, one step per prescaler tick. On the tick
// taken at zero it pulses tc and either reloads (periodic) or stops in DONE
// (one-shot). stop aborts to IDLE from any state and wins over start.
//   clk           : system clock, all state on the rising edge
//   rst           : asynchronous active-low reset
//   bus.load_val  : start/reload value, sampled on an accepted start
//   bus.prescale  : divide ratio minus one, read live
//   bus.auto_reload: 1 = periodic, 0 = one-shot, sampled on start
//   bus.start     : one-cycle load-and-run request (also restarts)
//   bus.stop      : one-cycle abort to IDLE
//   bus.en        : count enable; low freezes the timer in HOLD
//   bus.count     : current count (registered)
//   bus.busy      : high in RUN or HOLD (registered)
//   bus.tc        : one-cycle terminal-count pulse (registered)
//   bus.expired   : high in DONE (registered)
// -----------------------------------------------------------------------------
module down_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic         clk,
    input  logic         rst,
    down_timer_if.slave  bus
);

    timer_state_e     state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic             mode_q,    mode_d;
    logic             tc_q,      tc_d;
    logic             busy_q,    busy_d;
    logic             expired_q, expired_d;

    logic             loaded;
    logic             ps_clr;
    logic             ps_run;
    logic             tick;

    // RUN and HOLD both mean "loaded"; the state only records whether en was
    // high last cycle. Counting follows the live en, so every enabled cycle
    // contributes to the period and resuming from HOLD loses no cycle.
    assign loaded = (state_q == RUN) || (state_q == HOLD);
    assign ps_clr = bus.stop || bus.start;
    assign ps_run = loaded && bus.en;

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (ps_clr),
        .run      (ps_run),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    // Next-state, count and output decode. Priority: stop > start > en/tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (bus.stop) begin
            // A terminal tick on the same cycle is dropped along with tc.
            state_d = IDLE;
            count_d = '0;
        end else if (bus.start) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            mode_d   = bus.auto_reload;
            state_d  = bus.en ? RUN : HOLD;
        end else if (loaded) begin
            if (!bus.en) begin
                state_d = HOLD;
            end else begin
                state_d = RUN;
                if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        // Terminal tick: count is never decremented from zero.
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
        end
        // IDLE and DONE ignore en and only leave on start or stop.

        busy_d    = (state_d == RUN) || (state_d == HOLD);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.tc      = tc_q;
    assign bus.expired = expired_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
// Directed bench for down_timer. Each driven cycle pushes the expected
// outputs into a scoreboard queue; after the edge the entry is popped and
// compared against the registered outputs.
// -----------------------------------------------------------------------------
module tb_down_timer;
    import timer_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    down_timer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] count;
        logic         busy;
        logic         tc;
        logic         expired;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural reference of the timer
    timer_state_e  m_state;
    logic [W-1:0]  m_count;
    logic [W-1:0]  m_reload;
    logic          m_mode;
    logic [PW-1:0] m_pcnt;
    logic          m_tc;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state  = IDLE;
        m_count  = '0;
        m_reload = '0;
        m_mode   = 1'b0;
        m_pcnt   = '0;
        m_tc     = 1'b0;
    endtask

    // Advance the reference by one rising edge using the inputs now driven.
    task automatic model_step();
        logic tick;
        m_tc = 1'b0;
        if (bus.stop) begin
            m_state = IDLE;
            m_count = '0;
            m_pcnt  = '0;
        end else if (bus.start) begin
            m_count  = bus.load_val;
            m_reload = bus.load_val;
            m_mode   = bus.auto_reload;
            m_pcnt   = '0;
            m_state  = bus.en ? RUN : HOLD;
        end else if (m_state == RUN || m_state == HOLD) begin
            if (!bus.en) begin
                m_state = HOLD;
            end else begin
                m_state = RUN;
                tick    = (m_pcnt == bus.prescale);
                m_pcnt  = tick ? '0 : m_pcnt + PW'(1);
                if (tick) begin
                    if (m_count != 0) begin
                        m_count = m_count - W'(1);
                    end else begin
                        m_tc = 1'b1;
                        if (m_mode) m_count = m_reload;
                        else        m_state = DONE;
                    end
                end
            end
        end
    endtask

    // One clock: predict, push, let the edge happen, pop and compare.
    task automatic cyc(input string tag);
        exp_t e;
        model_step();
        e.count   = m_count;
        e.busy    = (m_state == RUN) || (m_state == HOLD);
        e.tc      = m_tc;
        e.expired = (m_state == DONE);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".count"},   bus.count,   e.count);
            check({tag, ".busy"},    W'(bus.busy),    W'(e.busy));
            check({tag, ".tc"},      W'(bus.tc),      W'(e.tc));
            check({tag, ".expired"}, W'(bus.expired), W'(e.expired));
        end
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        cyc("stop");
        bus.stop = 1'b0;
    endtask

    // Watchdog: the directed sequence is short; anything longer is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tc_at;
        int n_tc;
        int last_tc;
        int bad_gap;
        int first6;

        bus.load_val    = '0;
        bus.prescale    = '0;
        bus.auto_reload = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.en          = 1'b0;
        model_reset();

        // ---------------- reset state
        rst = 1'b0;
        #12;
        check("reset.count",   bus.count,       '0);
        check("reset.busy",    W'(bus.busy),    '0);
        check("reset.tc",      W'(bus.tc),      '0);
        check("reset.expired", W'(bus.expired), '0);
        rst = 1'b1;
        cyc("idle");
        bus.en = 1'b1;
        cyc("idle_en");

        // ---------------- one-shot: load 3, prescale 0
        bus.load_val    = W'(3);
        bus.prescale    = '0;
        bus.auto_reload = 1'b0;
        bus.start       = 1'b1;
        cyc("os_start");
        bus.start = 1'b0;
        tc_at = -1;
        for (int i = 1; i <= 6; i++) begin
            cyc("os");
            if (bus.tc === 1'b1 && tc_at < 0) tc_at = i;
        end
        check("os.tc_edge", W'(tc_at), W'(4));
        check("os.expired", W'(bus.expired), W'(1));

        // ---------------- periodic: load 2, prescale 1
        pulse_stop();
        bus.load_val    = W'(2);
        bus.prescale    = PW'(1);
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        cyc("per_start");
        bus.start = 1'b0;
        n_tc    = 0;
        last_tc = -1;
        bad_gap = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc("per");
            if (bus.tc === 1'b1) begin
                if (last_tc >= 0 && (i - last_tc) != 6) bad_gap++;
                last_tc = i;
                n_tc++;
            end
        end
        check("per.tc_count", W'(n_tc), W'(5));
        check("per.tc_gap",   W'(bad_gap), '0);

        // ---------------- hold: load 5, en low for 3 cycles at count 3
        pulse_stop();
        bus.load_val    = W'(5);
        bus.prescale    = '0;
        bus.auto_reload = 1'b0;
        bus.start       = 1'b1;
        cyc("hold_start");
        bus.start = 1'b0;
        cyc("hold_pre");
        cyc("hold_pre");
        check("hold.count3", bus.count, W'(3));
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("hold_frozen");
        end
        check("hold.state", W'(dut.state_q), W'(HOLD));
        bus.en = 1'b1;
        tc_at = -1;
        for (int i = 6; i <= 12; i++) begin
            cyc("hold_resume");
            if (bus.tc === 1'b1 && tc_at < 0) tc_at = i;
        end
        check("hold.tc_edge", W'(tc_at), W'(9));

        // ---------------- stop on the terminal tick
        pulse_stop();
        bus.load_val    = W'(1);
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        cyc("st_start");
        bus.start = 1'b0;
        cyc("st_to_zero");
        bus.stop = 1'b1;
        cyc("st_collide");
        bus.stop = 1'b0;
        check("st.no_tc", W'(bus.tc), '0);
        cyc("st_after");
        check("st.state", W'(dut.state_q), W'(IDLE));

        // ---------------- start and stop together
        bus.load_val = W'(4);
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        cyc("ss_both");
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss.busy", W'(bus.busy), '0);
        cyc("ss_after");

        // ---------------- restart during RUN resets the prescaler
        bus.load_val    = W'(9);
        bus.prescale    = PW'(3);
        bus.auto_reload = 1'b0;
        bus.start       = 1'b1;
        cyc("rs_start");
        bus.start = 1'b0;
        cyc("rs_run");
        cyc("rs_run");
        bus.load_val = W'(7);
        bus.start    = 1'b1;
        cyc("rs_restart");
        bus.start = 1'b0;
        check("rs.count7", bus.count, W'(7));
        first6 = -1;
        for (int i = 1; i <= 8; i++) begin
            cyc("rs_count");
            if (bus.count === W'(6) && first6 < 0) first6 = i;
        end
        check("rs.first_step", W'(first6), W'(4));

        // ---------------- load 0, prescale 0, periodic: tc every cycle
        pulse_stop();
        bus.load_val    = '0;
        bus.prescale    = '0;
        bus.auto_reload = 1'b1;
        bus.start       = 1'b1;
        cyc("z_start");
        bus.start = 1'b0;
        n_tc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("z_run");
            if (bus.tc === 1'b1) n_tc++;
        end
        check("z.tc_every_cycle", W'(n_tc), W'(5));

        // ---------------- maximum load value
        pulse_stop();
        bus.load_val    = '1;
        bus.auto_reload = 1'b0;
        bus.start       = 1'b1;
        cyc("max_start");
        bus.start = 1'b0;
        check("max.load", bus.count, 32'hFFFF_FFFF);
        cyc("max_step");
        check("max.step", bus.count, 32'hFFFF_FFFE);
        cyc("max_step2");

        // ---------------- async reset mid-run, released between edges
        #2;
        rst = 1'b0;
        #1;
        check("arst.count",   bus.count,       '0);
        check("arst.busy",    W'(bus.busy),    '0);
        check("arst.tc",      W'(bus.tc),      '0);
        check("arst.expired", W'(bus.expired), '0);
        check("arst.state",   W'(dut.state_q), W'(IDLE));
        model_reset();
        #2;
        rst = 1'b1;
        n_tc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("arst_after");
            if (bus.tc === 1'b1) n_tc++;
        end
        check("arst.no_tc", W'(n_tc), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_down_timer
